// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and NZCV flag helper for alu_mc.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_SLT   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1000;
    localparam logic [3:0] OP_NAND  = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {N,Z,C,V}; C and V are only meaningful for ADD/SUB.
    function automatic logic [3:0] calc_nzcv(
        input logic res_msb,
        input logic res_zero,
        input logic is_add,
        input logic is_sub,
        input logic a_msb,
        input logic b_msb,
        input logic carry
    );
        logic v;
        v = 1'b0;
        if (is_add)
            v = (a_msb == b_msb) && (res_msb != a_msb);
        else if (is_sub)
            v = (a_msb != b_msb) && (res_msb != a_msb);
        return {res_msb, res_zero, (is_add || is_sub) ? carry : 1'b0, v};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// W-step shift-add multiplier / restoring divider sharing one 2W accumulator.
// Result lo = product low / quotient, hi = product high / remainder.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_div,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi
);

    localparam int CW = $clog2(W);

    logic           r_run;
    logic [CW-1:0]  r_cnt;
    logic           r_div;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;

    logic [W:0]     w_mul_sum;
    logic [W:0]     w_rem_sh;
    logic [W:0]     w_rem_sub;
    logic [2*W-1:0] w_acc_nxt;

    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_rem_sh  = r_acc[2*W-1:W-1];
        w_rem_sub = w_rem_sh - {1'b0, r_b};
        w_acc_nxt = {w_mul_sum, r_acc[W-1:1]};
        // Remainder sits in the upper half, quotient bits shift in at the bottom.
        if (r_div) begin
            if (w_rem_sh >= {1'b0, r_b})
                w_acc_nxt = {w_rem_sub[W-1:0], r_acc[W-2:0], 1'b1};
            else
                w_acc_nxt = {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= CW'(W - 1);
        end else if (r_run) begin
            if (r_cnt == '0)
                r_run <= 1'b0;
            else
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc <= {{W{1'b0}}, i_a};
            r_b   <= i_b;
            r_div <= i_div;
        end else if (r_run) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Final step result is taken straight from the next-state value.
    assign o_done = r_run && (r_cnt == '0);
    assign o_lo   = w_acc_nxt[W-1:0];
    assign o_hi   = w_acc_nxt[2*W-1:W];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and registered result/NZCV flags.
// Define ALU_MULDIV_EN to enable iterative MUL/MULHU/DIVU/REMU (opcodes 1100-1111).
module alu_mc
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] I1,
    input  logic [W-1:0] I2,
    input  logic [3:0]   alu_ctr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic         N_flag,
    output logic         Z_flag,
    output logic         C_flag,
    output logic         V_flag,
    output logic         busy
);

    localparam int SHW = $clog2(W);

    state_t         r_state;
    logic [W-1:0]   r_out;
    logic [3:0]     r_nzcv;

    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [W-1:0]   w_res;
    logic           w_carry;
    logic [SHW-1:0] w_shamt;
    logic [3:0]     w_flags;
    logic           w_is_md;

    always_comb begin
        w_shamt = I2[SHW-1:0];
        w_sum   = {1'b0, I1} + {1'b0, I2};
        w_diff  = {1'b0, I1} - {1'b0, I2};
        w_res   = '0;
        w_carry = 1'b0;
        case (alu_ctr)
            OP_AND:  w_res = I1 & I2;
            OP_OR:   w_res = I1 | I2;
            OP_ADD:  begin w_res = w_sum[W-1:0];  w_carry = w_sum[W];  end
            OP_SUB:  begin w_res = w_diff[W-1:0]; w_carry = w_diff[W]; end
            OP_SLT:  w_res[0] = ($signed(I1) < $signed(I2));
            OP_SLL:  w_res = I1 << w_shamt;
            OP_SRL:  w_res = I1 >> w_shamt;
            OP_XOR:  w_res = I1 ^ I2;
            OP_NOR:  w_res = ~(I1 | I2);
            OP_NAND: w_res = ~(I1 & I2);
            OP_SRA:  w_res = $signed(I1) >>> w_shamt;
            OP_SLTU: w_res[0] = (I1 < I2);
            default: w_res = '0;
        endcase
        w_flags = calc_nzcv(w_res[W-1], w_res == '0, alu_ctr == OP_ADD,
                            alu_ctr == OP_SUB, I1[W-1], I2[W-1], w_carry);
    end

`ifdef ALU_MULDIV_EN
    logic         r_sel_hi;
    logic         w_md_done;
    logic [W-1:0] w_md_lo;
    logic [W-1:0] w_md_hi;
    logic [W-1:0] w_md_res;

    assign w_is_md  = (alu_ctr[3:2] == 2'b11);
    assign w_md_res = r_sel_hi ? w_md_hi : w_md_lo;

    alu_muldiv_iter #(.W(W)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (in_valid && (r_state == ST_IDLE) && w_is_md),
        .i_div   (alu_ctr[1]),
        .i_a     (I1),
        .i_b     (I2),
        .o_done  (w_md_done),
        .o_lo    (w_md_lo),
        .o_hi    (w_md_hi)
    );

    // MULHU and REMU both take the upper accumulator half.
    always_ff @(posedge clk) begin
        if (in_valid && (r_state == ST_IDLE))
            r_sel_hi <= alu_ctr[0];
    end

    assign busy = (r_state == ST_BUSY);
`else
    assign w_is_md = 1'b0;
    assign busy    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_out   <= '0;
            r_nzcv  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_is_md) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_DONE;
                            r_out   <= w_res;
                            r_nzcv  <= w_flags;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                ST_BUSY: begin
                    if (w_md_done) begin
                        r_state <= ST_DONE;
                        r_out   <= w_md_res;
                        r_nzcv  <= calc_nzcv(w_md_res[W-1], w_md_res == '0,
                                             1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out       = r_out;
    assign N_flag    = r_nzcv[3];
    assign Z_flag    = r_nzcv[2];
    assign C_flag    = r_nzcv[1];
    assign V_flag    = r_nzcv[0];

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] I1 = '0;
    logic [31:0] I2 = '0;
    logic [3:0]  alu_ctr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        N_flag, Z_flag, C_flag, V_flag;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  nzcv;
    } exp_t;

    alu_mc #(.W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I1        (I1),
        .I2        (I2),
        .alu_ctr   (alu_ctr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .N_flag    (N_flag),
        .Z_flag    (Z_flag),
        .C_flag    (C_flag),
        .V_flag    (V_flag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, prod;
        longint sa, sb, t;
        int sh;
        exp_t e;
        logic c, v;
        ua = 64'(a); ub = 64'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sh = int'(b[4:0]);
        c = 1'b0; v = 1'b0;
        e.res = '0;
        prod = ua * ub;
        case (op)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h2: begin
                e.res = 32'(ua + ub);
                c = (ua + ub) > 64'hFFFF_FFFF;
                t = sa + sb;
                v = (t > SMAX) || (t < SMIN);
            end
            4'h3: begin
                e.res = 32'(ua - ub);
                c = ua < ub;
                t = sa - sb;
                v = (t > SMAX) || (t < SMIN);
            end
            4'h4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'h5: e.res = a << sh;
            4'h6: e.res = a >> sh;
            4'h7: e.res = a ^ b;
            4'h8: e.res = ~(a | b);
            4'h9: e.res = ~(a & b);
            4'hA: e.res = 32'(sa >>> sh);
            4'hB: e.res = (ua < ub) ? 32'd1 : 32'd0;
            4'hC: e.res = MD ? 32'(prod) : 32'd0;
            4'hD: e.res = MD ? 32'(prod >> 32) : 32'd0;
            4'hE: e.res = !MD ? 32'd0 : (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            default: e.res = !MD ? 32'd0 : (b == 0) ? a : 32'(ua % ub);
        endcase
        e.nzcv = {e.res[31], e.res == 32'd0, c, v};
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        return (MD && op >= 4'hC) ? 33 : 1;
    endfunction

    function automatic int exp_busy(input logic [3:0] op);
        return (MD && op >= 4'hC) ? 32 : 0;
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_001F};
        if ($urandom_range(0, 3) == 0)
            return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // Presents one op, then counts edges (including the accept edge) until out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        I1 = a; I2 = b; alu_ctr = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctr = 4'($urandom); I1 = $urandom; I2 = $urandom;
        lat = 1; bcnt = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (out !== 32'd0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
        total++; if ({N_flag, Z_flag, C_flag, V_flag} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {N_flag, Z_flag, C_flag, V_flag}); end
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_valid_busy got=%b%b want=00", out_valid, busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        logic [3:0]  ops [3];
        logic [31:0] as [3];
        logic [31:0] bs [3];
        logic [35:0] want [3];
        int lat, bc;
        ops  = '{4'h2, 4'h3, 4'h3};
        as   = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        bs   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        want = '{{32'h8000_0000, 4'b1001}, {32'hFFFF_FFFF, 4'b1010}, {32'h7FFF_FFFF, 4'b0001}};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], lat, bc);
            total++; if (lat !== 1) begin bad++; $display("FAIL addsub_lat%0d got=%0d want=1", i, lat); end
            total++; if ({out, N_flag, Z_flag, C_flag, V_flag} !== want[i]) begin
                bad++; $display("FAIL addsub%0d got=%h/%b want=%h/%b", i, out, {N_flag, Z_flag, C_flag, V_flag}, want[i][35:4], want[i][3:0]);
            end
            release_result();
        end
    endtask

    task automatic test_random_single();
        exp_t e;
        logic [3:0] op;
        logic [31:0] a, b;
        int lat, bc;
        for (int i = 0; i < 48; i++) begin
            op = 4'($urandom_range(0, 11));
            a = pick_operand(); b = pick_operand();
            e = model(op, a, b);
            issue(op, a, b, lat, bc);
            total++; if (lat !== 1 || bc !== 0) begin bad++; $display("FAIL single_lat op=%h got=%0d/%0d want=1/0", op, lat, bc); end
            total++; if ({out, N_flag, Z_flag, C_flag, V_flag} !== e) begin
                bad++; $display("FAIL single op=%h a=%h b=%h got=%h/%b want=%h/%b", op, a, b, out, {N_flag, Z_flag, C_flag, V_flag}, e.res, e.nzcv);
            end
            release_result();
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops [11];
        logic [31:0] as [11];
        logic [31:0] bs [11];
        exp_t e;
        int lat, bc;
        ops = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hF, 4'hC, 4'hD, 4'hE, 4'hF, 4'hE, 4'hC};
        as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'd100, 0, 0, 0, 0, 0, 0};
        bs  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd7, 0, 0, 0, 0, 0, 0};
        for (int i = 5; i < 11; i++) begin
            as[i] = pick_operand();
            bs[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : pick_operand();
        end
        for (int i = 0; i < 11; i++) begin
            e = model(ops[i], as[i], bs[i]);
            issue(ops[i], as[i], bs[i], lat, bc);
            total++; if (lat !== exp_lat(ops[i])) begin bad++; $display("FAIL md_lat op=%h got=%0d want=%0d", ops[i], lat, exp_lat(ops[i])); end
            total++; if (bc !== exp_busy(ops[i])) begin bad++; $display("FAIL md_busy op=%h got=%0d want=%0d", ops[i], bc, exp_busy(ops[i])); end
            total++; if ({out, N_flag, Z_flag, C_flag, V_flag} !== e) begin
                bad++; $display("FAIL md op=%h a=%h b=%h got=%h/%b want=%h/%b", ops[i], as[i], bs[i], out, {N_flag, Z_flag, C_flag, V_flag}, e.res, e.nzcv);
            end
            release_result();
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int lat, bc;
        e = model(4'h3, 32'h8000_0000, 32'h1);
        issue(4'h3, 32'h8000_0000, 32'h1, lat, bc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; alu_ctr = 4'($urandom); I1 = $urandom; I2 = $urandom;
            @(posedge clk); #1;
            total++; if ({out, N_flag, Z_flag, C_flag, V_flag} !== e) begin
                bad++; $display("FAIL hold_data%0d got=%h/%b want=%h/%b", i, out, {N_flag, Z_flag, C_flag, V_flag}, e.res, e.nzcv);
            end
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL hold_ctrl%0d got=%b%b%b want=100", i, out_valid, in_ready, busy);
            end
        end
        in_valid = 1'b1; alu_ctr = 4'h2;
        release_result();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release got=%b%b want=01", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] op;
        logic [31:0] a, b;
        int lat, bc;
        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(0, 15));
            a = pick_operand(); b = pick_operand();
            e = model(op, a, b);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, in_ready); end
            issue(op, a, b, lat, bc);
            total++; if (lat !== exp_lat(op) || {out, N_flag, Z_flag, C_flag, V_flag} !== e) begin
                bad++; $display("FAIL b2b op=%h lat=%0d/%0d got=%h/%b want=%h/%b", op, lat, exp_lat(op), out, {N_flag, Z_flag, C_flag, V_flag}, e.res, e.nzcv);
            end
            release_result();
        end
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        int lat, bc;
        I1 = 32'h1234_5678; I2 = 32'h9; alu_ctr = 4'hC; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        total++; if (busy !== MD) begin bad++; $display("FAIL midbusy_pre got=%b want=%b", busy, MD); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midbusy_ctrl got=%b%b%b want=001", busy, out_valid, in_ready);
        end
        total++; if ({out, N_flag, Z_flag, C_flag, V_flag} !== 36'd0) begin
            bad++; $display("FAIL midbusy_data got=%h/%b want=0/0000", out, {N_flag, Z_flag, C_flag, V_flag});
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midbusy_abandon got=%b%b want=00", out_valid, busy); end
        e = model(4'h2, 32'h0000_00FF, 32'hFFFF_FF01);
        issue(4'h2, 32'h0000_00FF, 32'hFFFF_FF01, lat, bc);
        total++; if (lat !== 1 || {out, N_flag, Z_flag, C_flag, V_flag} !== e) begin
            bad++; $display("FAIL post_reset_add lat=%0d got=%h/%b want=%h/%b", lat, out, {N_flag, Z_flag, C_flag, V_flag}, e.res, e.nzcv);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_random_single();
        test_muldiv();
        test_hold();
        test_back_to_back();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
